// File: rtl/axi_lite_ram_slave_if.sv
// AXI4-Lite bus between a single master and the RAM responder.
// The master modport drives valids, payloads and the response readies.
interface axi_lite_ram_slave_if #(
   parameter int unsigned MEM_WIDTH = 21
);
   logic [MEM_WIDTH-1:0] axi_araddr;
   logic                 axi_arvalid;
   logic                 axi_arready;
   logic [2:0]           axi_arprot;
   logic [31:0]          axi_rdata;
   logic [1:0]           axi_rresp;
   logic                 axi_rvalid;
   logic                 axi_rready;
   logic [MEM_WIDTH-1:0] axi_awaddr;
   logic                 axi_awvalid;
   logic                 axi_awready;
   logic [2:0]           axi_awprot;
   logic [31:0]          axi_wdata;
   logic [3:0]           axi_wstrb;
   logic                 axi_wvalid;
   logic                 axi_wready;
   logic [1:0]           axi_bresp;
   logic                 axi_bvalid;
   logic                 axi_bready;

   modport master (
      output axi_araddr, axi_arvalid, axi_arprot, axi_rready,
      output axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
      input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
      input  axi_awready, axi_wready, axi_bresp, axi_bvalid
   );

   modport slave (
      input  axi_araddr, axi_arvalid, axi_arprot, axi_rready,
      input  axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
      output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
      output axi_awready, axi_wready, axi_bresp, axi_bvalid
   );
endinterface

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite responder backed by a word-organised RAM. Serves one single-beat
// transaction at a time, honours byte strobes and always answers OKAY.
module axi_lite_ram_slave #(
   parameter int unsigned MEM_WIDTH = 21
) (
   input logic                 clk,
   input logic                 rstn,
   axi_lite_ram_slave_if.slave bus
);

   localparam int unsigned IdxW  = MEM_WIDTH - 2;
   localparam int unsigned Depth = 2 ** IdxW;

   typedef enum logic [2:0] {
      StIdle,
      StWaitW,
      StWaitAw,
      StWrResp,
      StRdResp
   } state_e;

   state_e            state_q;
   logic [IdxW-1:0]   aw_idx_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic [31:0]       rdata_q;
   logic              rvalid_q;
   logic              bvalid_q;

   logic [31:0]       mem [Depth];

   logic              arready;
   logic              awready;
   logic              wready;
   logic              ar_hs;
   logic              aw_hs;
   logic              w_hs;
   logic [IdxW-1:0]   ar_idx;
   logic [IdxW-1:0]   aw_idx;

   logic              commit;
   logic [IdxW-1:0]   commit_idx;
   logic [31:0]       commit_data;
   logic [3:0]        commit_strb;

   assign ar_idx = bus.axi_araddr[MEM_WIDTH-1:2];
   assign aw_idx = bus.axi_awaddr[MEM_WIDTH-1:2];

   // Readies are gated by rstn so nothing is accepted while reset is held.
   always_comb begin
      arready = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      if (rstn) begin
         unique case (state_q)
            StIdle: begin
               awready = 1'b1;
               wready  = 1'b1;
               arready = ~bus.axi_awvalid & ~bus.axi_wvalid;
            end
            StWaitW:  wready  = 1'b1;
            StWaitAw: awready = 1'b1;
            default: ;
         endcase
      end
   end

   assign ar_hs = bus.axi_arvalid & arready;
   assign aw_hs = bus.axi_awvalid & awready;
   assign w_hs  = bus.axi_wvalid & wready;

   // The commit edge is whichever edge completes the second of the AW/W handshakes.
   always_comb begin
      commit      = 1'b0;
      commit_idx  = aw_idx_q;
      commit_data = wdata_q;
      commit_strb = wstrb_q;
      unique case (state_q)
         StIdle: begin
            if (aw_hs && w_hs) begin
               commit      = 1'b1;
               commit_idx  = aw_idx;
               commit_data = bus.axi_wdata;
               commit_strb = bus.axi_wstrb;
            end
         end
         StWaitW: begin
            if (w_hs) begin
               commit      = 1'b1;
               commit_data = bus.axi_wdata;
               commit_strb = bus.axi_wstrb;
            end
         end
         StWaitAw: begin
            if (aw_hs) begin
               commit     = 1'b1;
               commit_idx = aw_idx;
            end
         end
         default: ;
      endcase
   end

   // RAM contents survive reset; commit can only fire while rstn is high.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (commit_strb[b]) begin
               mem[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         rvalid_q <= 1'b0;
         bvalid_q <= 1'b0;
         rdata_q  <= '0;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else begin
         if (aw_hs) begin
            aw_idx_q <= aw_idx;
         end
         if (w_hs) begin
            wdata_q <= bus.axi_wdata;
            wstrb_q <= bus.axi_wstrb;
         end
         unique case (state_q)
            StIdle: begin
               if (commit) begin
                  state_q  <= StWrResp;
                  bvalid_q <= 1'b1;
               end else if (aw_hs) begin
                  state_q <= StWaitW;
               end else if (w_hs) begin
                  state_q <= StWaitAw;
               end else if (ar_hs) begin
                  rdata_q  <= mem[ar_idx];
                  rvalid_q <= 1'b1;
                  state_q  <= StRdResp;
               end
            end
            StWaitW, StWaitAw: begin
               if (commit) begin
                  state_q  <= StWrResp;
                  bvalid_q <= 1'b1;
               end
            end
            StWrResp: begin
               if (bus.axi_bready) begin
                  bvalid_q <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            StRdResp: begin
               if (bus.axi_rready) begin
                  rvalid_q <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.axi_arready = arready;
   assign bus.axi_awready = awready;
   assign bus.axi_wready  = wready;
   assign bus.axi_rdata   = rdata_q;
   assign bus.axi_rvalid  = rvalid_q;
   assign bus.axi_rresp   = 2'b00;
   assign bus.axi_bvalid  = bvalid_q;
   assign bus.axi_bresp   = 2'b00;

   // Protection bits and the byte offset carry no meaning for this RAM.
   logic unused_ok;
   assign unused_ok = ^{bus.axi_arprot, bus.axi_awprot,
                        bus.axi_araddr[1:0], bus.axi_awaddr[1:0]};

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Scoreboard bench for axi_lite_ram_slave: stimulus pushes expected responses,
// a monitor pops and compares them; RAM behaviour comes from a word-map model.
module tb_axi_lite_ram_slave;

   localparam int unsigned MW = 12;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   axi_lite_ram_slave_if #(.MEM_WIDTH(MW)) bus ();

   axi_lite_ram_slave #(.MEM_WIDTH(MW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   exp_t        exp_q[$];
   logic [31:0] model[int];
   int          known[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          issued      = 0;
   int          done_cnt    = 0;
   bit          hold_ready  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: handshake not seen, expected within 50 cycles at %0t", name, $time);
   endtask

   // Monitor: owns rready/bready and compares every response against the queue.
   initial begin : monitor
      exp_t cur;
      bit   active;
      active = 1'b0;
      cur.is_read = 1'b0;
      cur.data = '0;
      bus.axi_rready = 1'b0;
      bus.axi_bready = 1'b0;
      forever begin
         @(negedge clk);
         bus.axi_rready = 1'b0;
         bus.axi_bready = 1'b0;
         if (!rstn) begin
            active = 1'b0;
         end else if (bus.axi_rvalid || bus.axi_bvalid) begin
            check("rvalid_bvalid_exclusive", 32'(bus.axi_rvalid & bus.axi_bvalid), 32'd0);
            if (!active) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_response: got rvalid=%0b bvalid=%0b, expected none",
                           bus.axi_rvalid, bus.axi_bvalid);
                  cur.is_read = bus.axi_rvalid;
                  cur.data = bus.axi_rdata;
               end else begin
                  cur = exp_q.pop_front();
               end
               active = 1'b1;
               check("resp_kind_is_read", 32'(bus.axi_rvalid), 32'(cur.is_read));
            end
            if (bus.axi_rvalid) begin
               check("rdata", bus.axi_rdata, cur.data);
               check("rresp", 32'(bus.axi_rresp), 32'd0);
            end else begin
               check("bresp", 32'(bus.axi_bresp), 32'd0);
            end
            if (!hold_ready && $urandom_range(0, 3) != 0) begin
               if (bus.axi_rvalid) bus.axi_rready = 1'b1;
               else bus.axi_bready = 1'b1;
               active = 1'b0;
               done_cnt++;
            end
         end
      end
   end

   task automatic wait_done();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (done_cnt < issued && n < 300);
      if (done_cnt < issued) begin
         vectors++;
         miscompares++;
         $display("FAIL response_timeout: %0d responses seen, expected %0d", done_cnt, issued);
         issued = done_cnt;
         exp_q.delete();
      end
      #1;
   endtask

   task automatic drive_aw(input logic [MW-1:0] a, input int d);
      bit ok = 1'b0;
      if (d > 0) begin
         repeat (d) @(posedge clk);
         #1;
      end
      bus.axi_awaddr  = a;
      bus.axi_awprot  = 3'($urandom);
      bus.axi_awvalid = 1'b1;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = bus.axi_awready;
      end
      if (!ok) timeout("awready");
      @(posedge clk);
      #1;
      bus.axi_awvalid = 1'b0;
   endtask

   task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int d);
      bit ok = 1'b0;
      if (d > 0) begin
         repeat (d) @(posedge clk);
         #1;
      end
      bus.axi_wdata  = data;
      bus.axi_wstrb  = strb;
      bus.axi_wvalid = 1'b1;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = bus.axi_wready;
      end
      if (!ok) timeout("wready");
      @(posedge clk);
      #1;
      bus.axi_wvalid = 1'b0;
   endtask

   task automatic drive_ar(input logic [MW-1:0] a);
      bit ok = 1'b0;
      bus.axi_araddr  = a;
      bus.axi_arprot  = 3'($urandom);
      bus.axi_arvalid = 1'b1;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = bus.axi_arready;
      end
      if (!ok) timeout("arready");
      @(posedge clk);
      #1;
      bus.axi_arvalid = 1'b0;
   endtask

   // Reference model: a byte-merged word map, only words with fully known contents.
   task automatic model_write(input logic [MW-1:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      int          idx = int'(addr[MW-1:2]);
      logic [31:0] cur = model.exists(idx) ? model[idx] : 32'h0;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
      end
      if (model.exists(idx) || strb == 4'hF) begin
         if (!model.exists(idx)) known.push_back(idx);
         model[idx] = cur;
      end
   endtask

   task automatic push_exp(input logic is_read, input logic [31:0] data);
      exp_t e;
      e.is_read = is_read;
      e.data = data;
      exp_q.push_back(e);
      issued++;
   endtask

   task automatic do_write(input logic [MW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int daw, input int dw, input int hold);
      model_write(addr, data, strb);
      push_exp(1'b0, 32'h0);
      hold_ready = (hold > 0);
      fork
         drive_aw(addr, daw);
         drive_w(data, strb, dw);
      join
      for (int c = 0; c < ((hold > 0) ? hold : 1); c++) begin
         @(negedge clk);
         check("bvalid_after_commit", 32'(bus.axi_bvalid), 32'd1);
         if (hold > 0) begin
            check("awready_in_wr_resp", 32'(bus.axi_awready), 32'd0);
            check("wready_in_wr_resp", 32'(bus.axi_wready), 32'd0);
         end
      end
      hold_ready = 1'b0;
      wait_done();
   endtask

   task automatic do_read(input logic [MW-1:0] addr, input int hold);
      int idx = int'(addr[MW-1:2]);
      push_exp(1'b1, model[idx]);
      hold_ready = (hold > 0);
      drive_ar(addr);
      for (int c = 0; c < ((hold > 0) ? hold : 1); c++) begin
         @(negedge clk);
         check("rvalid_after_ar", 32'(bus.axi_rvalid), 32'd1);
         if (hold > 0) check("arready_in_rd_resp", 32'(bus.axi_arready), 32'd0);
      end
      hold_ready = 1'b0;
      wait_done();
   endtask

   initial begin : stimulus
      logic [MW-3:0] widx;
      logic [MW-1:0] a;
      bit            ok;
      rstn = 1'b0;
      bus.axi_arvalid = 1'b0;
      bus.axi_awvalid = 1'b0;
      bus.axi_wvalid  = 1'b0;
      bus.axi_araddr  = '0;
      bus.axi_awaddr  = '0;
      bus.axi_arprot  = '0;
      bus.axi_awprot  = '0;
      bus.axi_wdata   = '0;
      bus.axi_wstrb   = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_rvalid", 32'(bus.axi_rvalid), 32'd0);
      check("reset_bvalid", 32'(bus.axi_bvalid), 32'd0);
      check("reset_rdata", bus.axi_rdata, 32'd0);
      check("reset_arready", 32'(bus.axi_arready), 32'd0);
      check("reset_awready", 32'(bus.axi_awready), 32'd0);
      check("reset_wready", 32'(bus.axi_wready), 32'd0);
      @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check("idle_arready", 32'(bus.axi_arready), 32'd1);
      check("idle_awready", 32'(bus.axi_awready), 32'd1);
      check("idle_wready", 32'(bus.axi_wready), 32'd1);
      @(posedge clk);
      #1;

      // Write then read back
      do_write(12'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      do_read(12'h100, 0);

      // Partial strobe and empty strobe
      do_write(12'h200, 32'h11223344, 4'hF, 0, 0, 0);
      do_write(12'h200, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
      check("model_partial_strobe", model[12'h200 >> 2], 32'h11BB33DD);
      do_read(12'h202, 0);
      do_write(12'h200, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
      do_read(12'h200, 0);

      // W before AW: W at cycle 0, AW at cycle 3
      fork
         do_write(12'h300, 32'hCAFEF00D, 4'hF, 3, 0, 0);
         begin
            @(negedge clk);
            check("wba_wready_c0", 32'(bus.axi_wready), 32'd1);
            for (int c = 1; c <= 3; c++) begin
               @(negedge clk);
               check("wba_awready", 32'(bus.axi_awready), 32'd1);
               check("wba_wready", 32'(bus.axi_wready), 32'd0);
               check("wba_bvalid_low", 32'(bus.axi_bvalid), 32'd0);
            end
         end
      join
      do_read(12'h300, 0);

      // Simultaneous AR and AW/W: write served first, read sees new data
      model_write(12'h100, 32'h0BADC0DE, 4'hF);
      push_exp(1'b0, 32'h0);
      push_exp(1'b1, model[12'h100 >> 2]);
      bus.axi_awaddr = 12'h100;
      bus.axi_wdata = 32'h0BADC0DE;
      bus.axi_wstrb = 4'hF;
      bus.axi_araddr = 12'h100;
      bus.axi_awvalid = 1'b1;
      bus.axi_wvalid = 1'b1;
      bus.axi_arvalid = 1'b1;
      @(negedge clk);
      check("sim_arready_blocked", 32'(bus.axi_arready), 32'd0);
      check("sim_awready", 32'(bus.axi_awready), 32'd1);
      @(posedge clk);
      #1;
      bus.axi_awvalid = 1'b0;
      bus.axi_wvalid = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = bus.axi_arready;
      end
      if (!ok) timeout("sim_arready");
      @(posedge clk);
      #1;
      bus.axi_arvalid = 1'b0;
      @(negedge clk);
      check("sim_rvalid", 32'(bus.axi_rvalid), 32'd1);
      wait_done();

      // Backpressure on R and B
      do_read(12'h100, 3);
      do_write(12'h304, 32'h13572468, 4'hF, 1, 0, 3);

      // Reset mid-read: response dropped, RAM retained
      push_exp(1'b1, model[12'h300 >> 2]);
      hold_ready = 1'b1;
      drive_ar(12'h300);
      @(negedge clk);
      check("pre_reset_rvalid", 32'(bus.axi_rvalid), 32'd1);
      #1 rstn = 1'b0;
      #1;
      check("midrst_rvalid", 32'(bus.axi_rvalid), 32'd0);
      check("midrst_rdata", bus.axi_rdata, 32'd0);
      check("midrst_arready", 32'(bus.axi_arready), 32'd0);
      check("midrst_awready", 32'(bus.axi_awready), 32'd0);
      check("midrst_wready", 32'(bus.axi_wready), 32'd0);
      exp_q.delete();
      issued = done_cnt;
      hold_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;
      do_read(12'h100, 0);
      do_read(12'h200, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 150; i++) begin
         if (known.size() == 0 || $urandom_range(0, 1) == 1) begin
            widx = (MW-2)'($urandom_range(256, 287));
            a = {widx, 2'($urandom)};
            do_write(a, $urandom, model.exists(int'(widx)) ? 4'($urandom) : 4'hF,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
         end else begin
            widx = (MW-2)'(known[$urandom_range(0, known.size() - 1)]);
            a = {widx, 2'($urandom)};
            do_read(a, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
         end
      end

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      miscompares++;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_lite_ram_slave.md
Name: axi_lite_ram_slave

Overview:
- AXI4-Lite responder backed by a word-organised on-chip RAM; the responder end of the mem_axi_* bus driven by mmu.
- Serves one transaction at a time: one single-beat read or one single-beat write.
- Honours byte strobes and returns OKAY on every response.
- Used as the main memory in FPGA builds and simulation.

Parameters:
- MEM_WIDTH, 21, byte-address width. RAM depth is 2^(MEM_WIDTH-2) 32-bit words.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- axi_araddr  in  MEM_WIDTH  read byte address
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address ready
- axi_arprot  in  3  ignored
- axi_rdata  out  32  read data
- axi_rresp  out  2  read response, always 2'b00
- axi_rvalid  out  1  read data valid
- axi_rready  in  1  read data ready
- axi_awaddr  in  MEM_WIDTH  write byte address
- axi_awvalid  in  1  write address valid
- axi_awready  out  1  write address ready
- axi_awprot  in  3  ignored
- axi_wdata  in  32  write data
- axi_wstrb  in  4  byte strobes, bit i enables wdata[8i+7:8i]
- axi_wvalid  in  1  write data valid
- axi_wready  out  1  write data ready
- axi_bresp  out  2  write response, always 2'b00
- axi_bvalid  out  1  write response valid
- axi_bready  in  1  write response ready

Behaviour:
- Word index = addr[MEM_WIDTH-1:2]. addr[1:0] is ignored; there is no misalignment error.
- States: IDLE, WAIT_W (AW taken), WAIT_AW (W taken), WR_RESP, RD_RESP.
- Reset (rstn low, asynchronous):
  - state goes to IDLE; rvalid=0, bvalid=0, rdata=0.
  - all ready outputs are forced to 0 while rstn=0.
  - RAM contents are not cleared.
- Reset mid-transaction drops the transaction: no response is issued. A write is committed to RAM only if its commit edge occurred before reset.
- Ready outputs (combinational from state, valids and rstn):
  - IDLE: awready=1, wready=1, arready = ~awvalid & ~wvalid. A pending write has priority over a simultaneous read.
  - WAIT_W: wready=1, others 0.
  - WAIT_AW: awready=1, others 0.
  - WR_RESP, RD_RESP: all readies 0.
- Write path:
  - A handshake on AW and/or W latches awaddr, wdata and wstrb.
  - If both handshakes complete at the same edge in IDLE: commit the RAM write at that edge and go to WR_RESP.
  - If only one completes, go to WAIT_W or WAIT_AW. Commit at the edge the other handshake completes, then go to WR_RESP.
  - Commit writes only the bytes with strobe set; other bytes keep their value. wstrb=0 writes nothing but still responds.
  - bvalid=1 from the cycle after commit. Held until the bvalid&bready edge, then return to IDLE.
- Read path:
  - The arvalid&arready edge in IDLE performs a synchronous RAM read and goes to RD_RESP.
  - rvalid=1 and rdata valid from the next cycle. rdata is stable while rvalid&~rready.
  - The rvalid&rready edge returns to IDLE, with rvalid=0 in the following cycle.
- Ordering: a read accepted after a write response sees the written data. Read-to-read throughput is 1 per 2 cycles minimum.
- The block never raises rvalid and bvalid together. No outstanding-transaction queue.

Test Plan:
- Write then read back:
  - Stimulus: AW=0x100, W=0xDEADBEEF, wstrb=4'hF in the same cycle, bready=1.
  - Response: bvalid the next cycle.
  - Then read AR=0x100: rvalid 1 cycle after the AR handshake, rdata=0xDEADBEEF, rresp=0.
- Partial strobe:
  - Stimulus: word 0x200 holds 0x11223344; write wdata=0xAABBCCDD with wstrb=4'b0101.
  - Response: a read returns 0x11BB33DD.
- W before AW:
  - Stimulus: wvalid at cycle 0, awvalid at cycle 3.
  - Response: wready handshake at cycle 0, state WAIT_AW, awready high cycles 1-3, commit at cycle 3, bvalid at cycle 4, read-back matches.
- Simultaneous AR and AW/W in IDLE:
  - Required: arready=0 while the write is served.
  - After the write response, the read is accepted and returns the new data.
- Backpressure:
  - Stimulus: hold rready=0 for 3 cycles after rvalid.
  - Response: rvalid and rdata stable, arready=0 throughout. A similar bready=0 hold keeps bvalid high.
- Reset mid-read:
  - Stimulus: drop rstn in RD_RESP.
  - Response: rvalid=0 immediately and all readies 0. After release, a read of an earlier written address still returns its data.
